// File: rtl/line_window_gen_pkg.sv
// Shared video definitions for the line window generator and its neighbours.
package video_pkg;

  localparam int DEFAULT_COLORDEPTH = 8;

  typedef logic [DEFAULT_COLORDEPTH-1:0] pixel_t;

  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } sync_t;

  function automatic int LINE_ADDR_W(input int max_line);
    return (max_line > 1) ? $clog2(max_line) : 1;
  endfunction

endpackage

// File: rtl/line_window_gen_if.sv
// Raster-in / column-vector-out bundle of line_window_gen; the slave side is the generator,
// the master side is the pixel source together with the downstream Sobel stage.
interface line_window_gen_if import video_pkg::*; #(
  parameter int COLORDEPTH = DEFAULT_COLORDEPTH,
  parameter int M_DEPTH    = 3
);

  logic [COLORDEPTH-1:0]              pixel_i;
  logic                               dv_i;
  logic                               hs_i;
  logic                               vs_i;
  logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect_o;
  logic                               dv_o;
  logic                               hs_o;
  logic                               vs_o;
  logic                               line_end_o;
  logic                               ovf_o;

  modport master (
    output pixel_i, dv_i, hs_i, vs_i,
    input  vect_o, dv_o, hs_o, vs_o, line_end_o, ovf_o
  );

  modport slave (
    input  pixel_i, dv_i, hs_i, vs_i,
    output vect_o, dv_o, hs_o, vs_o, line_end_o, ovf_o
  );

endinterface

// File: rtl/line_window_gen_line_ram.sv
// Simple dual-port line RAM: registered read that returns the old word on a same-address write.
module line_ram import video_pkg::*; #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = DEFAULT_COLORDEPTH,
  localparam int AW   = LINE_ADDR_W(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; the window masking hides stale contents.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/line_window_gen.sv
// Vertical window generator feeding the Sobel stage: M_DEPTH-1 chained line RAMs, 2-cycle latency.
// Build option LINE_WINDOW_EDGE_REPLICATE_EN: replicate the top valid row instead of zero fill.
module line_window_gen import video_pkg::*; #(
  parameter int COLORDEPTH = DEFAULT_COLORDEPTH,
  parameter int M_DEPTH    = 3,
  parameter int MAX_LINE   = 2048
) (
  input logic               clk,
  input logic               rst,
  line_window_gen_if.slave  bus
);

  localparam int AW  = LINE_ADDR_W(MAX_LINE);
  localparam int LVW = $clog2(M_DEPTH);
  localparam logic [AW-1:0]  LAST_COL = AW'(MAX_LINE - 1);
  localparam logic [LVW-1:0] LV_MAX   = LVW'(M_DEPTH - 1);

  logic [AW-1:0]                      col;
  logic [AW-1:0]                      col1;
  logic [LVW-1:0]                     lines_valid;
  logic [LVW-1:0]                     lv1;
  logic                               dv_d;
  logic                               vs_d;
  sync_t                              s1;
  logic [COLORDEPTH-1:0]              pix1;
  logic [COLORDEPTH-1:0]              rd [M_DEPTH-1];
  logic [M_DEPTH-1:0][COLORDEPTH-1:0] win;
  logic                               dv_fall;
  logic                               vs_rise;
  logic                               at_last;

  assign dv_fall = ~bus.dv_i & dv_d;
  assign vs_rise = bus.vs_i & ~vs_d;
  assign at_last = (col == LAST_COL);

  // RAM0 takes the new pixel; RAM k takes what RAM k-1 held one cycle later at the same column.
  for (genvar k = 0; k < M_DEPTH - 1; k++) begin : g_ram
    if (k == 0) begin : g_first
      line_ram #(.DEPTH(MAX_LINE), .WIDTH(COLORDEPTH)) u_ram (
        .clk   (clk),
        .we    (bus.dv_i),
        .waddr (col),
        .wdata (bus.pixel_i),
        .re    (bus.dv_i),
        .raddr (col),
        .rdata (rd[k])
      );
    end else begin : g_chain
      line_ram #(.DEPTH(MAX_LINE), .WIDTH(COLORDEPTH)) u_ram (
        .clk   (clk),
        .we    (s1.dv),
        .waddr (col1),
        .wdata (rd[k-1]),
        .re    (bus.dv_i),
        .raddr (col),
        .rdata (rd[k])
      );
    end
  end

  // Column counter, valid-line counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      lines_valid <= '0;
      dv_d        <= 1'b0;
      vs_d        <= 1'b0;
      bus.ovf_o   <= 1'b0;
    end else begin
      dv_d <= bus.dv_i;
      vs_d <= bus.vs_i;
      if (bus.dv_i && !at_last) col <= col + AW'(1);
      else if (!bus.dv_i)       col <= '0;
      // A frame start outranks a line end landing on the same edge.
      if (vs_rise)                                 lines_valid <= '0;
      else if (dv_fall && lines_valid != LV_MAX)   lines_valid <= lines_valid + LVW'(1);
      if (vs_rise)                  bus.ovf_o <= 1'b0;
      else if (bus.dv_i && at_last) bus.ovf_o <= 1'b1;
    end
  end

  // Stage 1: sync, pixel and line-valid count aligned with the registered RAM reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      pix1 <= '0;
      col1 <= '0;
      lv1  <= '0;
    end else begin
      s1   <= '{dv: bus.dv_i, hs: bus.hs_i, vs: bus.vs_i};
      pix1 <= bus.pixel_i;
      col1 <= col;
      lv1  <= lines_valid;
    end
  end

`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
  logic [COLORDEPTH-1:0] top_row;

  // Top-most row that belongs to the current frame.
  always_comb begin
    top_row = pix1;
    for (int k = 1; k < M_DEPTH; k++) begin
      top_row = (LVW'(k) == lv1) ? rd[k-1] : top_row;
    end
  end
`endif

  // Rows above the valid lines of this frame are filled instead of showing stale RAM data.
  always_comb begin
    win    = '0;
    win[0] = pix1;
    for (int k = 1; k < M_DEPTH; k++) begin
      if (LVW'(k) <= lv1) begin
        win[k] = rd[k-1];
      end else begin
`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
        win[k] = top_row;
`else
        win[k] = '0;
`endif
      end
    end
  end

  // Stage 2: output register; line_end looks ahead at the incoming dv.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vect_o     <= '0;
      bus.dv_o       <= 1'b0;
      bus.hs_o       <= 1'b0;
      bus.vs_o       <= 1'b0;
      bus.line_end_o <= 1'b0;
    end else begin
      bus.dv_o       <= s1.dv;
      bus.hs_o       <= s1.hs;
      bus.vs_o       <= s1.vs;
      bus.line_end_o <= s1.dv & ~bus.dv_i;
      if (s1.dv) bus.vect_o <= win;
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Randomised bench for line_window_gen against a per-column line-history model.
module tb_line_window_gen;
  import video_pkg::*;

  localparam int CD = 8;
  localparam int MD = 3;
  localparam int ML = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  line_window_gen_if #(.COLORDEPTH(CD), .M_DEPTH(MD)) bus ();

  line_window_gen #(.COLORDEPTH(CD), .M_DEPTH(MD), .MAX_LINE(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: per column, the pixels written there, most recent first (-1 = unknown).
  int hist [ML][MD-1];
  int lv, col;
  bit ovf_m, dv_prev, vs_prev, sat_prev;
  int last_vect [MD];
  bit last_chk  [MD];
  bit pend_dv, pend_hs, pend_vs;
  int pend_vect [MD];
  bit pend_chk  [MD];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    lv = 0; col = 0; ovf_m = 1'b0; dv_prev = 1'b0; vs_prev = 1'b0; sat_prev = 1'b0;
    pend_dv = 1'b0; pend_hs = 1'b0; pend_vs = 1'b0;
    for (int k = 0; k < MD; k++) begin
      last_vect[k] = 0; last_chk[k] = 1'b1; pend_vect[k] = 0; pend_chk[k] = 1'b1;
    end
    for (int c = 0; c < ML; c++)
      for (int k = 0; k < MD - 1; k++) hist[c][k] = -1;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.dv_i = 1'($urandom_range(0, 1));
      bus.pixel_i = 8'($urandom_range(0, 255));
      bus.hs_i = 1'b0;
      bus.vs_i = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_dv_o", 32'(bus.dv_o), 32'd0);
      check_eq("rst_hs_o", 32'(bus.hs_o), 32'd0);
      check_eq("rst_vs_o", 32'(bus.vs_o), 32'd0);
      check_eq("rst_line_end_o", 32'(bus.line_end_o), 32'd0);
      check_eq("rst_ovf_o", 32'(bus.ovf_o), 32'd0);
      for (int k = 0; k < MD; k++) check_eq($sformatf("rst_vect%0d", k), 32'(bus.vect_o[k]), 32'd0);
    end
    model_reset();
  endtask

  task automatic step(input int pix, input bit dv, input bit hs, input bit vs);
    int cv [MD];
    bit cc [MD];
    int addr;
    bit rep;
    @(negedge clk);
    rst = 1'b0;
    bus.pixel_i = pix[CD-1:0];
    bus.dv_i = dv;
    bus.hs_i = hs;
    bus.vs_i = vs;
    for (int k = 0; k < MD; k++) begin cv[k] = 0; cc[k] = 1'b1; end
    if (dv) begin
      addr = col;
      rep = sat_prev;
      cv[0] = pix;
      for (int k = 1; k < MD; k++) begin
        if (k <= lv) begin
          cv[k] = hist[addr][k-1];
          cc[k] = !rep && (cv[k] >= 0);
        end else begin
`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
          cv[k] = cv[lv]; cc[k] = cc[lv];
`else
          cv[k] = 0; cc[k] = 1'b1;
`endif
        end
      end
      for (int k = MD - 2; k > 0; k--) hist[addr][k] = hist[addr][k-1];
      hist[addr][0] = pix;
      if (rep) for (int k = 1; k < MD - 1; k++) hist[addr][k] = -1;
      if (col == ML - 1) ovf_m = 1'b1;
      else col++;
      sat_prev = (addr == ML - 1);
    end else begin
      sat_prev = 1'b0;
      if (dv_prev && lv < MD - 1) lv++;
      col = 0;
    end
    if (vs && !vs_prev) begin lv = 0; ovf_m = 1'b0; end
    dv_prev = dv;
    vs_prev = vs;
    @(posedge clk); #1;
    if (pend_dv) begin
      for (int k = 0; k < MD; k++) begin last_vect[k] = pend_vect[k]; last_chk[k] = pend_chk[k]; end
    end
    check_eq("dv_o", 32'(bus.dv_o), 32'(pend_dv));
    check_eq("hs_o", 32'(bus.hs_o), 32'(pend_hs));
    check_eq("vs_o", 32'(bus.vs_o), 32'(pend_vs));
    check_eq("line_end_o", 32'(bus.line_end_o), 32'(pend_dv && !dv));
    check_eq("ovf_o", 32'(bus.ovf_o), 32'(ovf_m));
    for (int k = 0; k < MD; k++)
      if (last_chk[k]) check_eq($sformatf("vect%0d", k), 32'(bus.vect_o[k]), 32'(last_vect[k]));
    pend_dv = dv; pend_hs = hs; pend_vs = vs;
    for (int k = 0; k < MD; k++) begin pend_vect[k] = cv[k]; pend_chk[k] = cc[k]; end
  endtask

  // mode 0: 16*line+col, 1: 0xAA, 2: random
  task automatic send_line(input int len, input int mode, input int lnum, input int gap);
    int p;
    for (int c = 0; c < len; c++) begin
      p = (mode == 0) ? ((16 * lnum + c) & 255) : (mode == 1) ? 170 : int'($urandom_range(0, 255));
      step(p, 1'b1, 1'b0, 1'b0);
    end
    for (int g = 0; g < gap; g++) step(0, 1'b0, (g == 0), 1'b0);
  endtask

  task automatic new_frame();
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.pixel_i = '0; bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0;
    model_reset();
    do_reset(3);

    // Ramp frame of 4-pixel lines with 2 idle cycles between lines.
    new_frame();
    for (int l = 0; l < 4; l++) send_line(4, 0, l, 2);

    // Single-pixel pulse, isolated sync pulses.
    step(90, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, (i == 1), 1'b0);

    // New frame after 5 lines, then a flat 0xAA line.
    new_frame();
    send_line(4, 1, 0, 2);
    send_line(4, 0, 1, 2);

    // Overflowing 10-pixel line; flag must hold until the next frame start.
    send_line(10, 2, 0, 2);
    send_line(3, 2, 1, 2);
    new_frame();
    send_line(5, 2, 0, 2);

    // Frame start on the same edge as a line end, and pixels while vs is high.
    send_line(4, 2, 1, 0);
    step(0, 1'b0, 1'b0, 1'b1);
    step(68, 1'b1, 1'b0, 1'b1);
    step(69, 1'b1, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of line 2, then a fresh frame.
    new_frame();
    send_line(4, 0, 0, 2);
    send_line(4, 0, 1, 2);
    step(32, 1'b1, 1'b0, 1'b0);
    step(33, 1'b1, 1'b0, 1'b0);
    do_reset(3);
    new_frame();
    for (int l = 0; l < 3; l++) send_line(4, 0, l, 2);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      new_frame();
      for (int l = 0; l < int'($urandom_range(2, 6)); l++)
        send_line(($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 11)) : int'($urandom_range(1, 7)),
                  2, l, $urandom_range(1, 3));
    end
    step(0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/line_window_gen.md
# line_window_gen

- Sits upstream of the Sobel gradient stage and supplies its vertical window.
- Takes a raster pixel stream with `dv`/`hs`/`vs` qualifiers and stores the last `M_DEPTH-1` lines in on-chip line RAM.
- Each valid beat emits a column vector of `M_DEPTH` vertically adjacent pixels, with sync signals delayed to match and a `line_end_o` strobe.
- Its outputs connect directly to the `vect_in`/`dv_i`/`hs_i`/`vs_i` inputs of the Sobel convolution block.

## Interface
Parameters:
- `COLORDEPTH`, 8, bits per pixel
- `M_DEPTH`, 3, window height (lines); legal range 2..7
- `MAX_LINE`, 2048, maximum pixels per line; address width `$clog2(MAX_LINE)`

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `pixel_i`  in  COLORDEPTH  incoming pixel
- `dv_i`  in  1  pixel valid
- `hs_i`  in  1  horizontal sync, active high
- `vs_i`  in  1  vertical sync, active high
- `vect_o`  out  [COLORDEPTH-1:0] x M_DEPTH
  - `vect_o[0]` is the current line; `vect_o[k]` is the pixel k lines above.
- `dv_o`  out  1  delayed `dv_i`
- `hs_o`  out  1  delayed `hs_i`
- `vs_o`  out  1  delayed `vs_i`
- `line_end_o`  out  1  high with the last `dv_o` beat of each line
- `ovf_o`  out  1  sticky line-overflow flag

## Operation
- Column counter `col`:
  - Increments on each `dv_i` beat.
  - Clears in the cycle after a `dv_i` falling edge (end of line).
- Line RAMs: `M_DEPTH-1` RAMs, each `MAX_LINE` deep, chained.
  - On a `dv_i` beat at address `col`, RAM0 reads the old value and writes `pixel_i`.
  - RAM k writes the value just read from RAM k-1 (read-before-write, same address).
- Valid-line counter `lines_valid`:
  - Increments on each `dv_i` falling edge.
  - Saturates at `M_DEPTH-1`.
  - Clears on a `vs_i` rising edge (frame start).
- Masking: for k > `lines_valid`, `vect_o[k]` is forced to 0. This hides stale RAM contents from the previous frame.
- Overflow: if `dv_i` is high with `col == MAX_LINE-1`:
  - That pixel is written and `col` holds (saturates).
  - Further pixels in the line overwrite the last address.
  - `ovf_o` sets; it clears only on a `vs_i` rising edge or `rst`.
- Simultaneous events:
  - A `vs_i` rising edge coinciding with a `dv_i` falling edge clears `lines_valid`; the clear wins.
  - `dv_i` high during `vs_i` high is processed normally.
- Output gating: `vect_o` updates only on `dv_o` beats and holds otherwise.

## Timing
- Two-stage pipeline.
  - Stage 1: RAM read, registered.
  - Stage 2: output register, with look-ahead at the stage-1 `dv` for `line_end_o`.
- Latency: `pixel_i`/`dv_i`/`hs_i`/`vs_i` to `vect_o`/`dv_o`/`hs_o`/`vs_o` is exactly 2 cycles.
- `line_end_o` = stage-2 `dv` AND NOT stage-1 `dv`. It is a single cycle, coincident with the last `dv_o` high of a line.
  - A one-pixel line gives `dv_o` and `line_end_o` high in the same cycle.
- Back-to-back lines with no `dv_i` gap are not supported; at least one idle cycle is required between lines.
- Reset values: all outputs 0, `col` = 0, `lines_valid` = 0, pipeline registers 0.
  - RAM contents are not cleared; masking covers them.
  - `rst` mid-line discards the partial line.
  - The first output after reset comes 2 cycles after the first `dv_i`.

## Configuration
- `LINE_WINDOW_EDGE_REPLICATE_EN`
  - Defined: rows beyond `lines_valid` replicate the top-most valid row instead of being zero, i.e. `vect_o[k] = vect_o[lines_valid]` for k > `lines_valid`. This gives border replication for the first lines of a frame.
  - Undefined: zero fill as described under Operation.

## Structure
- Shared package `video_pkg`:
  - `COLORDEPTH` default
  - `pixel_t` (`logic [COLORDEPTH-1:0]`)
  - a `sync_t` struct {`dv`, `hs`, `vs`}
  - `LINE_ADDR_W` function.
- Sub-module `line_ram`: simple dual-port, read-before-write RAM with registered read, `MAX_LINE` x `COLORDEPTH`. It is instantiated `M_DEPTH-1` times via generate.

## Test plan
1. `M_DEPTH=3`, frame of 4-pixel lines, pixel value = 16*line + col, 2 idle cycles between lines.
   - Line 0 outputs `vect_o` = {0,0,00..03}.
   - Line 2 col 1 outputs {01,11,21}.
   - `line_end_o` is high exactly on col 3 of each line.
2. Latency check: a single `dv_i` pulse at cycle t gives `dv_o` and `line_end_o` high at t+2 only; `hs_o`/`vs_o` edges are delayed exactly 2 cycles.
3. New frame: `vs_i` rising edge after 5 lines, then a line of value 0xAA.
   - `vect_o[1]` and `vect_o[2]` are 0, not previous-frame data.
   - With the macro defined, `vect_o` = {AA,AA,AA}.
4. Overflow with `MAX_LINE=8` and a 10-pixel line: `ovf_o` rises on the 8th pixel and stays high until the next `vs_i` rising edge.
5. `rst` asserted mid-line 2 of a frame, then a fresh frame: all outputs are 0 during reset, and the first line out has zeroed upper rows.
